// File: rtl/shift_seq_ctrl_if.sv
// Bundle between the lab-side command source and the shift-register sequencer.
// The master side issues commands and drives q_in; the slave side drives the register controls.
interface shift_seq_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 3
);
  logic              start;
  logic              dir;
  logic [CNT_W-1:0]  shift_cnt;
  logic [DATA_W-1:0] load_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [1:0]        s;
  logic [DATA_W-1:0] d;
  logic              oe;
  logic [DATA_W-1:0] q_in;

  modport master (
    output start, dir, shift_cnt, load_data, q_in,
    input  busy, done, result, s, d, oe
  );

  modport slave (
    input  start, dir, shift_cnt, load_data, q_in,
    output busy, done, result, s, d, oe
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a 4-bit universal shift register: load, shift N times, capture q.
// Every output comes straight from a flop; next values are computed in one always_comb.
module shift_seq_ctrl #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        s_q, s_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    d_d      = d_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        s_d    = S_HOLD;
        oe_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = ST_LOAD;
          dir_d   = bus.dir;
          cnt_d   = bus.shift_cnt;
          d_d     = bus.load_data;
          s_d     = S_LOAD;
          oe_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        // The register takes d on the edge ending this cycle.
        if (cnt_q != '0) begin
          state_d = ST_SHIFT;
          s_d     = dir_q ? S_LEFT : S_RIGHT;
        end else begin
          state_d = ST_CAPTURE;
          s_d     = S_HOLD;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_CAPTURE;
          s_d     = S_HOLD;
        end
      end
      ST_CAPTURE: begin
        state_d  = ST_DONE;
        result_d = bus.q_in;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        oe_d     = 1'b1;
        s_d      = S_HOLD;
      end
      ST_DONE: begin
        // start is deliberately not looked at here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = S_HOLD;
        oe_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      s_q      <= S_HOLD;
      d_q      <= '0;
      oe_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      d_q      <= d_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.s      = s_q;
  assign bus.d      = d_q;
  assign bus.oe     = oe_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a shift-register model feeds q_in, a command-level model predicts outputs.
// Directed plan cases pin the model with literal values, then a randomized phase runs against it.
module tb_shift_seq_ctrl;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  shift_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // 74194-style register, serial inputs tied low; a floating bus reads as zero.
  logic [3:0] q_model = 4'b0000;
  always @(posedge clk) begin
    case (bus.s)
      2'b11:   q_model <= bus.d;
      2'b01:   q_model <= {1'b0, q_model[3:1]};
      2'b10:   q_model <= {q_model[2:0], 1'b0};
      default: q_model <= q_model;
    endcase
  end
  assign bus.q_in = bus.oe ? 4'b0000 : q_model;

  // Command-level model: m_k is the cycle index since acceptance (1 = load cycle).
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_n = 0;
  bit         m_dir = 1'b0;
  logic [3:0] m_load = 4'b0000;
  logic [3:0] m_result = 4'b0000;

  function automatic logic [3:0] shifted(input logic [3:0] v, input bit left, input int n);
    int x;
    x = int'(v);
    x = left ? (x << n) : (x >> n);
    return x[3:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_result = 4'b0000;
    end else if (m_active) begin
      if (m_k == m_n + 2) m_result = shifted(m_load, m_dir, m_n);
      if (m_k == m_n + 3) m_active = 1'b0;
      else m_k++;
    end else if (bus.start) begin
      m_active = 1'b1;
      m_k      = 1;
      m_n      = int'(bus.shift_cnt);
      m_dir    = bus.dir;
      m_load   = bus.load_data;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] e_s;
      logic e_oe, e_busy, e_done;
      e_s = 2'b00; e_oe = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      if (m_active) begin
        if (m_k == 1) begin
          e_s = 2'b11; e_oe = 1'b0; e_busy = 1'b1;
        end else if (m_k <= m_n + 1) begin
          e_s = m_dir ? 2'b10 : 2'b01; e_oe = 1'b0; e_busy = 1'b1;
        end else if (m_k == m_n + 2) begin
          e_oe = 1'b0; e_busy = 1'b1;
        end else begin
          e_done = 1'b1;
        end
        if (m_k <= m_n + 2) check("d", 32'(bus.d), 32'(m_load));
      end
      check("s", 32'(bus.s), 32'(e_s));
      check("oe", 32'(bus.oe), 32'(e_oe));
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("done", 32'(bus.done), 32'(e_done));
      check("result", 32'(bus.result), 32'(m_result));
    end
  end

  // Issue one command from idle; optionally pulse a conflicting start at cycle inj.
  task automatic run_cmd(input logic [3:0] ld, input logic dr, input logic [2:0] n,
                         input int inj, output int lat, output int ndone);
    bus.start = 1'b1; bus.dir = dr; bus.shift_cnt = n; bus.load_data = ld;
    lat = -1; ndone = 0;
    for (int c = 1; c <= int'(n) + 6; c++) begin
      @(negedge clk);
      bus.start = (c == inj);
      if (c == inj) begin
        bus.load_data = ~ld; bus.dir = ~dr; bus.shift_cnt = 3'd5;
      end
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int lat, nd;
    bus.start = 1'b1; bus.dir = 1'b0; bus.shift_cnt = 3'd3; bus.load_data = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s", 32'(bus.s), 32'h0);
    check("rst_oe", 32'(bus.oe), 32'h1);
    check("rst_d", 32'(bus.d), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_result", 32'(bus.result), 32'h0);
    chk_en = 1'b1;
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(4'b0100, 1'b0, 3'd1, 0, lat, nd);
    check("t2_result", 32'(bus.result), 32'b0010);
    check("t2_latency", 32'(lat), 32'd4);
    run_cmd(4'b0011, 1'b1, 3'd2, 0, lat, nd);
    check("t3_result", 32'(bus.result), 32'b1100);
    check("t3_latency", 32'(lat), 32'd5);
    run_cmd(4'b1010, 1'b0, 3'd0, 0, lat, nd);
    check("t4_result", 32'(bus.result), 32'b1010);
    check("t4_latency", 32'(lat), 32'd3);
    run_cmd(4'b0001, 1'b1, 3'd3, 2, lat, nd);
    check("t5_result", 32'(bus.result), 32'b1000);
    check("t5_latency", 32'(lat), 32'd6);
    check("t5_done_count", 32'(nd), 32'd1);
    run_cmd(4'b1111, 1'b0, 3'd7, 0, lat, nd);
    check("max_cnt_latency", 32'(lat), 32'd10);
    check("max_cnt_result", 32'(bus.result), 32'b0000);

    // Reset in the middle of a long shift.
    bus.start = 1'b1; bus.dir = 1'b1; bus.shift_cnt = 3'd7; bus.load_data = 4'b1011;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_busy_before", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_s", 32'(bus.s), 32'h0);
    check("t6_oe", 32'(bus.oe), 32'h1);
    check("t6_busy", 32'(bus.busy), 32'h0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("t6_no_done", 32'(nd), 32'd0);
    run_cmd(4'b1001, 1'b1, 3'd1, 0, lat, nd);
    check("t6_after_result", 32'(bus.result), 32'b0010);
    check("t6_after_latency", 32'(lat), 32'd4);

    // Randomized traffic, including occasional resets and starts at any time.
    repeat (1500) begin
      @(negedge clk);
      rst_n         = ($urandom_range(0, 119) != 0);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.dir       = 1'($urandom);
      bus.shift_cnt = 3'($urandom);
      bus.load_data = 4'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b0;
    repeat (12) @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
